// File: rtl/stat_cnt_engine.sv
// Statistics counter engine: read-modify-write of per-address saturating counters
// through a 2-cycle-latency memory port, with CPU read-and-clear and post-reset table sweep.
module stat_cnt_engine #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter int INC_WIDTH  = 8
) (
  input  logic                  clockCore,
  input  logic                  resetCore,
  input  logic                  evtVld,
  output logic                  evtReady,
  input  logic [ADDR_WIDTH-1:0] evtAddr,
  input  logic [INC_WIDTH-1:0]  evtInc,
  input  logic                  clrReq,
  input  logic [ADDR_WIDTH-1:0] clrAddr,
  output logic                  clrAck,
  output logic [DATA_WIDTH-1:0] clrData,
  output logic                  initDone,
  output logic                  ctrlMemRd,
  output logic [ADDR_WIDTH-1:0] ctrlMemRdAddr,
  input  logic [DATA_WIDTH-1:0] ctrlMemRdData,
  output logic                  ctrlMemWr,
  output logic [ADDR_WIDTH-1:0] ctrlMemWrAddr,
  output logic [DATA_WIDTH-1:0] ctrlMemWrData
);

  typedef enum logic [0:0] {INIT = 1'b0, RUN = 1'b1} state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1'b1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = {ADDR_WIDTH{1'b1}};

  // Zero-extended add that clamps to all ones when the carry-out is set.
  function automatic logic [DATA_WIDTH-1:0] satAdd(input logic [DATA_WIDTH-1:0] base,
                                                   input logic [INC_WIDTH-1:0]  inc);
    logic [DATA_WIDTH:0] sum;
    sum = {1'b0, base} + {{(DATA_WIDTH - INC_WIDTH + 1){1'b0}}, inc};
    return sum[DATA_WIDTH] ? {DATA_WIDTH{1'b1}} : sum[DATA_WIDTH-1:0];
  endfunction

  state_t                  state_r;
  logic [ADDR_WIDTH-1:0]   initCnt_r;
  logic                    initWr_r;
  logic [ADDR_WIDTH-1:0]   initWrAddr_r;
  logic                    initDone_r;
  logic                    clrBusy_r;
  logic                    s1Vld_r, s1Clr_r;
  logic [ADDR_WIDTH-1:0]   s1Addr_r;
  logic [INC_WIDTH-1:0]    s1Inc_r;
  logic                    wVld_r, wClr_r;
  logic [ADDR_WIDTH-1:0]   wAddr_r;
  logic [INC_WIDTH-1:0]    wInc_r;
  logic                    s2Vld_r, s2Clr_r;
  logic [ADDR_WIDTH-1:0]   s2Addr_r;
  logic [INC_WIDTH-1:0]    s2Inc_r;
  logic                    clrAck_r;
  logic [DATA_WIDTH-1:0]   clrData_r;
  logic                    clrIssue_s, evtIssue_s, evtReady_s;
  logic                    memWr_s;
  logic [ADDR_WIDTH-1:0]   memWrAddr_s;
  logic [DATA_WIDTH-1:0]   memWrData_s;

  // A pending clear wins the issue slot; events are held off only for that cycle.
  assign clrIssue_s = initDone_r & clrReq & ~clrBusy_r;
  assign evtReady_s = initDone_r & ~(clrReq & ~clrBusy_r);
  assign evtIssue_s = evtVld & evtReady_s;

  // INIT sweep: one registered zero-write per cycle, then initDone one cycle after the last.
  always_ff @(posedge clockCore or negedge resetCore) begin
    if (!resetCore) begin
      state_r      <= INIT;
      initCnt_r    <= {ADDR_WIDTH{1'b0}};
      initWr_r     <= 1'b0;
      initWrAddr_r <= {ADDR_WIDTH{1'b0}};
      initDone_r   <= 1'b0;
    end else begin
      case (state_r)
        INIT: begin
          initWr_r     <= 1'b1;
          initWrAddr_r <= initCnt_r;
          initCnt_r    <= initCnt_r + ADDR_ONE;
          state_r      <= (initCnt_r == ADDR_MAX) ? RUN : INIT;
        end
        RUN: begin
          initWr_r   <= 1'b0;
          initDone_r <= 1'b1;
        end
        default: begin
          state_r <= INIT;
        end
      endcase
    end
  end

  // Issue -> read (S1) -> wait -> data return (S2) pipeline, plus clear handshake.
  always_ff @(posedge clockCore or negedge resetCore) begin
    if (!resetCore) begin
      s1Vld_r   <= 1'b0;
      s1Clr_r   <= 1'b0;
      s1Addr_r  <= {ADDR_WIDTH{1'b0}};
      s1Inc_r   <= {INC_WIDTH{1'b0}};
      wVld_r    <= 1'b0;
      wClr_r    <= 1'b0;
      wAddr_r   <= {ADDR_WIDTH{1'b0}};
      wInc_r    <= {INC_WIDTH{1'b0}};
      s2Vld_r   <= 1'b0;
      s2Clr_r   <= 1'b0;
      s2Addr_r  <= {ADDR_WIDTH{1'b0}};
      s2Inc_r   <= {INC_WIDTH{1'b0}};
      clrBusy_r <= 1'b0;
      clrAck_r  <= 1'b0;
      clrData_r <= {DATA_WIDTH{1'b0}};
    end else begin
      s1Vld_r <= clrIssue_s | evtIssue_s;
      if (clrIssue_s) begin
        s1Clr_r  <= 1'b1;
        s1Addr_r <= clrAddr;
        s1Inc_r  <= {INC_WIDTH{1'b0}};
      end else if (evtIssue_s) begin
        s1Clr_r  <= 1'b0;
        s1Addr_r <= evtAddr;
        s1Inc_r  <= evtInc;
      end else begin
        s1Clr_r  <= s1Clr_r;
        s1Addr_r <= s1Addr_r;
        s1Inc_r  <= s1Inc_r;
      end
      wVld_r   <= s1Vld_r;
      wClr_r   <= s1Clr_r;
      wAddr_r  <= s1Addr_r;
      wInc_r   <= s1Inc_r;
      s2Vld_r  <= wVld_r;
      s2Clr_r  <= wClr_r;
      s2Addr_r <= wAddr_r;
      s2Inc_r  <= wInc_r;
      clrAck_r <= s2Vld_r & s2Clr_r;
      if (s2Vld_r && s2Clr_r) begin
        clrData_r <= ctrlMemRdData;
      end else begin
        clrData_r <= clrData_r;
      end
      // Busy spans the ack cycle so a still-held clrReq cannot re-issue.
      if (clrIssue_s) begin
        clrBusy_r <= 1'b1;
      end else if (clrAck_r) begin
        clrBusy_r <= 1'b0;
      end else begin
        clrBusy_r <= clrBusy_r;
      end
    end
  end

  // Write port: sweep writes or the S2 update, driven in the data-return cycle.
  always_comb begin
    memWr_s     = 1'b0;
    memWrAddr_s = {ADDR_WIDTH{1'b0}};
    memWrData_s = {DATA_WIDTH{1'b0}};
    if (initWr_r) begin
      memWr_s     = 1'b1;
      memWrAddr_s = initWrAddr_r;
      memWrData_s = {DATA_WIDTH{1'b0}};
    end else if (s2Vld_r) begin
      memWr_s     = 1'b1;
      memWrAddr_s = s2Addr_r;
      memWrData_s = s2Clr_r ? {DATA_WIDTH{1'b0}} : satAdd(ctrlMemRdData, s2Inc_r);
    end else begin
      memWr_s     = 1'b0;
      memWrAddr_s = {ADDR_WIDTH{1'b0}};
      memWrData_s = {DATA_WIDTH{1'b0}};
    end
  end

  assign evtReady      = evtReady_s;
  assign initDone      = initDone_r;
  assign clrAck        = clrAck_r;
  assign clrData       = clrData_r;
  assign ctrlMemRd     = s1Vld_r;
  assign ctrlMemRdAddr = s1Addr_r;
  assign ctrlMemWr     = memWr_s;
  assign ctrlMemWrAddr = memWrAddr_s;
  assign ctrlMemWrData = memWrData_s;

endmodule

// File: tb/tb_stat_cnt_engine.sv
// Directed bench for stat_cnt_engine with a 2-cycle-latency forwarding memory model.
module tb_stat_cnt_engine;

  logic        clockCore;
  logic        resetCore;
  logic        evtVld;
  logic        evtReady;
  logic [7:0]  evtAddr;
  logic [7:0]  evtInc;
  logic        clrReq;
  logic [7:0]  clrAddr;
  logic        clrAck;
  logic [15:0] clrData;
  logic        initDone;
  logic        ctrlMemRd;
  logic [7:0]  ctrlMemRdAddr;
  logic [15:0] ctrlMemRdData;
  logic        ctrlMemWr;
  logic [7:0]  ctrlMemWrAddr;
  logic [15:0] ctrlMemWrData;

  logic [15:0] memArr [256];
  logic [7:0]  rdAddrD1, rdAddrD2;
  logic        preloadEn;
  logic [7:0]  preloadAddr;
  logic [15:0] preloadData;

  int numChecks = 0;
  int numFails  = 0;

  stat_cnt_engine #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .INC_WIDTH(8)) dut (
    .clockCore     (clockCore),
    .resetCore     (resetCore),
    .evtVld        (evtVld),
    .evtReady      (evtReady),
    .evtAddr       (evtAddr),
    .evtInc        (evtInc),
    .clrReq        (clrReq),
    .clrAddr       (clrAddr),
    .clrAck        (clrAck),
    .clrData       (clrData),
    .initDone      (initDone),
    .ctrlMemRd     (ctrlMemRd),
    .ctrlMemRdAddr (ctrlMemRdAddr),
    .ctrlMemRdData (ctrlMemRdData),
    .ctrlMemWr     (ctrlMemWr),
    .ctrlMemWrAddr (ctrlMemWrAddr),
    .ctrlMemWrData (ctrlMemWrData)
  );

  initial clockCore = 1'b0;
  always #5 clockCore = ~clockCore;

  // Memory: data for a read at cycle r appears at r+2 and sees writes made through r+1.
  always @(posedge clockCore) begin
    rdAddrD1 <= ctrlMemRdAddr;
    rdAddrD2 <= rdAddrD1;
    if (ctrlMemWr) begin
      memArr[ctrlMemWrAddr] <= ctrlMemWrData;
    end else if (preloadEn) begin
      memArr[preloadAddr] <= preloadData;
    end
  end
  assign ctrlMemRdData = memArr[rdAddrD2];

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    numChecks++;
    if (obs !== exp) begin
      numFails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Hex digits, high to low: evtReady initDone clrAck ctrlMemRd ctrlMemWr.
  function automatic logic [31:0] flags();
    return {12'd0, 3'd0, evtReady, 3'd0, initDone, 3'd0, clrAck, 3'd0, ctrlMemRd, 3'd0, ctrlMemWr};
  endfunction

  task automatic checkResetVals(input string tag);
    checkVal({tag, "Flags"},  flags(), 32'h00000);
    checkVal({tag, "RdAddr"}, 32'(ctrlMemRdAddr), 32'h0);
    checkVal({tag, "WrAddr"}, 32'(ctrlMemWrAddr), 32'h0);
    checkVal({tag, "WrData"}, 32'(ctrlMemWrData), 32'h0);
    checkVal({tag, "ClrData"}, 32'(clrData), 32'h0);
  endtask

  initial begin
    resetCore   = 1'b0;
    evtVld      = 1'b0;
    evtAddr     = 8'd0;
    evtInc      = 8'd0;
    clrReq      = 1'b0;
    clrAddr     = 8'd0;
    preloadEn   = 1'b0;
    preloadAddr = 8'd0;
    preloadData = 16'd0;
    repeat (3) @(negedge clockCore);
    checkResetVals("rst0");
    resetCore = 1'b1;

    // Sweep: cycles 1..256 write zero to addr k-1; a clrReq pulse mid-sweep is ignored.
    for (int k = 1; k <= 256; k++) begin
      @(negedge clockCore);
      clrReq  = (k >= 10 && k < 20);
      clrAddr = 8'd3;
      checkVal("initFlags",  flags(), 32'h00001);
      checkVal("initWrAddr", 32'(ctrlMemWrAddr), 32'(k - 1));
      checkVal("initWrData", 32'(ctrlMemWrData), 32'h0);
    end
    @(negedge clockCore);
    checkVal("initDoneFlags", flags(), 32'h11000);

    // Single event addr 5 inc 3, issued in cycle 257.
    evtVld  = 1'b1;
    evtAddr = 8'd5;
    evtInc  = 8'd3;
    @(negedge clockCore);
    evtVld = 1'b0;
    checkVal("evt5RdFlags", flags(), 32'h11010);
    checkVal("evt5RdAddr",  32'(ctrlMemRdAddr), 32'd5);
    @(negedge clockCore);
    checkVal("evt5Gap", flags(), 32'h11000);
    @(negedge clockCore);
    checkVal("evt5WrFlags", flags(), 32'h11001);
    checkVal("evt5WrAddr",  32'(ctrlMemWrAddr), 32'd5);
    checkVal("evt5WrData",  32'(ctrlMemWrData), 32'd3);
    @(negedge clockCore);

    // Four events to addr 7, then clear of addr 7 colliding with an inc-2 event.
    for (int i = 0; i <= 9; i++) begin
      logic expRdy, expAck, expRd, expWr;
      logic [15:0] expData;
      @(negedge clockCore);
      evtVld  = (i <= 5);
      evtAddr = 8'd7;
      evtInc  = (i >= 4) ? 8'd2 : 8'd1;
      clrReq  = (i >= 4 && i <= 7);
      clrAddr = 8'd7;
      #1;
      expRdy  = (i != 4);
      expAck  = (i == 8);
      expRd   = (i >= 1 && i <= 6);
      expWr   = (i >= 3 && i <= 8);
      expData = (i == 7) ? 16'd0 : (i == 8) ? 16'd2 : 16'(i - 2);
      checkVal($sformatf("seqFlags%0d", i), flags(),
               {12'd0, 3'd0, expRdy, 4'h1, 3'd0, expAck, 3'd0, expRd, 3'd0, expWr});
      if (expWr) begin
        checkVal($sformatf("seqWrAddr%0d", i), 32'(ctrlMemWrAddr), 32'd7);
        checkVal($sformatf("seqWrData%0d", i), 32'(ctrlMemWrData), 32'(expData));
      end
      if (expAck) begin
        checkVal("clrData", 32'(clrData), 32'd4);
      end
    end

    // Saturation: addr 9 preloaded to 0xFFFE, then inc 5 and inc 1.
    @(negedge clockCore);
    preloadEn   = 1'b1;
    preloadAddr = 8'd9;
    preloadData = 16'hFFFE;
    @(negedge clockCore);
    preloadEn = 1'b0;
    for (int j = 0; j <= 4; j++) begin
      @(negedge clockCore);
      evtVld  = (j <= 1);
      evtAddr = 8'd9;
      evtInc  = (j == 0) ? 8'd5 : 8'd1;
      if (j >= 3) begin
        checkVal($sformatf("satFlags%0d", j),  flags(), 32'h11001);
        checkVal($sformatf("satWrAddr%0d", j), 32'(ctrlMemWrAddr), 32'd9);
        checkVal($sformatf("satWrData%0d", j), 32'(ctrlMemWrData), 32'hFFFF);
      end
    end
    evtVld = 1'b0;
    @(negedge clockCore);

    // Reset with three events (addr 20..22) in the read/wait/return stages.
    for (int j = 0; j <= 2; j++) begin
      @(negedge clockCore);
      evtVld  = 1'b1;
      evtAddr = 8'(20 + j);
      evtInc  = 8'd1;
    end
    @(negedge clockCore);
    evtVld    = 1'b0;
    resetCore = 1'b0;
    #1;
    checkResetVals("rstMid");
    for (int j = 0; j < 2; j++) begin
      @(negedge clockCore);
      checkResetVals("rstHold");
    end
    resetCore = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clockCore);
      checkVal("reinitFlags",  flags(), 32'h00001);
      checkVal("reinitWrAddr", 32'(ctrlMemWrAddr), 32'(k - 1));
    end
    checkVal("noWr20", 32'(memArr[20]), 32'h0);
    checkVal("noWr21", 32'(memArr[21]), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule

// File: doc/stat_cnt_engine.md
# stat_cnt_engine

Read-modify-write statistics counter engine. It owns the logic (ctrl) port of the dual-port flop-out memory controller and keeps one saturating DATA_WIDTH counter per address. It accepts increment events and CPU-side read-and-clear requests, one operation per cycle, and clears the whole table after reset.

## Interface
- ADDR_WIDTH, 8: counter table address width (2^ADDR_WIDTH entries)
- DATA_WIDTH, 16: counter width
- INC_WIDTH, 8: increment width, must be <= DATA_WIDTH
- clockCore  in  1  core clock
- resetCore  in  1  asynchronous, active-low reset
- evtVld  in  1  increment event valid
- evtReady  out  1  event accepted when evtVld & evtReady
- evtAddr  in  ADDR_WIDTH  counter index
- evtInc  in  INC_WIDTH  increment amount, zero-extended
- clrReq  in  1  read-and-clear request, level, held until clrAck
- clrAddr  in  ADDR_WIDTH  counter to read and clear, stable while clrReq
- clrAck  out  1  one-cycle pulse, clrData valid
- clrData  out  DATA_WIDTH  counter value before clear
- initDone  out  1  table sweep complete
- ctrlMemRd / ctrlMemRdAddr  out  1 / ADDR_WIDTH  memory read request
- ctrlMemRdData  in  DATA_WIDTH  read data, 2 cycles after ctrlMemRd
- ctrlMemWr / ctrlMemWrAddr / ctrlMemWrData  out  1 / ADDR_WIDTH / DATA_WIDTH  memory write

## Operation
- States: INIT and RUN. Reset enters INIT.
- INIT: write 0 to addresses 0 .. 2^ADDR_WIDTH-1 in ascending order, one per cycle. During INIT, ctrlMemRd = 0 and evtReady = 0, and clrReq is ignored. After the last address, move to RUN and set initDone = 1. initDone stays 1 until reset.
- RUN issue stage (S0): pick at most one operation per cycle.
  - Priority 1: a pending clr. That is clrReq = 1 and no clr already in flight (clrBusy = 0).
  - Priority 2: an event.
  - evtReady = initDone & ~(clrReq & ~clrBusy).
- Issuing an operation registers ctrlMemRd = 1 and ctrlMemRdAddr for the next cycle (S1). The operation then travels S1 -> S2.
- S2 (read data returns):
  - Event: ctrlMemWr = 1, ctrlMemWrData = sat(ctrlMemRdData + evtInc). If the DATA_WIDTH+1-bit sum overflows, write all ones.
  - Clr: ctrlMemWr = 1 with data 0. Register clrData = ctrlMemRdData and clrAck = 1 for the next cycle, then clear clrBusy.
  - ctrlMemWr, ctrlMemWrAddr and ctrlMemWrData are combinational from S2 state and ctrlMemRdData. They must be driven in the same cycle as data return.
- At most one write per cycle in either state. Write and read in the same cycle are allowed.
- Coherence: the downstream port must forward writes issued 1 or 2 cycles before read data returns to the same address. Back-to-back operations to one address then need no stall.
- A clr and an event to the same address in adjacent cycles are applied in issue order.

## Timing
- Reset values: evtReady 0, initDone 0, clrAck 0, clrData 0, ctrlMemRd 0, ctrlMemRdAddr 0, ctrlMemWr 0, ctrlMemWrAddr 0, ctrlMemWrData 0. All pipeline valids and clrBusy are 0.
- INIT:
  - First write is in the first cycle after reset release.
  - INIT lasts 2^ADDR_WIDTH cycles.
  - initDone and evtReady rise in the cycle after the last INIT write.
- Event accepted at cycle t: ctrlMemRd at t+1, write at t+3.
- Clr accepted at t: ctrlMemRd at t+1, zero write at t+3, clrAck/clrData at t+4.
- Throughput is one operation per cycle sustained. Events are blocked only for the single cycle a clr is issued.
- Reset mid-operation drops all in-flight operations with no write and no ack, and restarts INIT at address 0.

## Test plan
- INIT sweep, ADDR_WIDTH=8: 256 consecutive writes, addresses 0..255, data 0. initDone = 1 at cycle 257. No ctrlMemRd during the sweep.
- Single event, addr 5, inc 3: ctrlMemRd addr 5 at t+1; write addr 5 data 3 at t+3.
- Four back-to-back events, addr 7, inc 1, memory model with 1- and 2-cycle write forwarding: writes to addr 7 with data 1, 2, 3, 4 on consecutive cycles.
- Saturation: preload addr 9 = 0xFFFE, event inc 5: write 0xFFFF. A following inc 1 writes 0xFFFF again.
- Read-and-clear: after the four events, clrReq addr 7 while evtVld is also asserted. evtReady = 0 for one cycle, clr issues first, write 0 to addr 7, clrAck with clrData = 4. The event issues the next cycle.
- Reset asserted with 3 operations in flight: no further ctrlMemWr from them, all outputs at reset values, INIT restarts at address 0.
